aq_djpeg_ycbcr_bank: RTL and testbench

AQ_DJPEG_YCBCR_BANK -- requirements
Module: aq_djpeg_ycbcr_bank

---
 rtl/aq_djpeg_pkg.sv | 39 +++
 rtl/aq_djpeg_sdp_ram.sv | 35 +++
 rtl/aq_djpeg_ycbcr_bank.sv | 177 +++++++++++++++++
 tb/tb_aq_djpeg_ycbcr_bank.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aq_djpeg_pkg.sv
// Shared encodings and helpers for the JPEG YCbCr MCU bank buffer.
package aq_djpeg_pkg;

  // MCU format as latched at DataInit
  typedef enum logic [1:0] {
    MODE_GRAY = 2'd0,
    MODE_444  = 2'd1,
    MODE_422  = 2'd2,
    MODE_420  = 2'd3
  } jpegMode_t;

  // Block codes carried on DataInColor
  localparam logic [2:0] COLOR_Y0 = 3'd0;
  localparam logic [2:0] COLOR_Y1 = 3'd1;
  localparam logic [2:0] COLOR_Y2 = 3'd2;
  localparam logic [2:0] COLOR_Y3 = 3'd3;
  localparam logic [2:0] COLOR_CB = 3'd4;
  localparam logic [2:0] COLOR_CR = 3'd5;

  // Block whose final sample closes an MCU in the given format
  function automatic logic [2:0] lastBlock(input jpegMode_t mode);
    case (mode)
      MODE_GRAY: lastBlock = COLOR_Y0;
      default:   lastBlock = COLOR_CR;
    endcase
  endfunction

  // True when the block code is part of an MCU of the given format
  function automatic logic colorInMode(input jpegMode_t mode, input logic [2:0] color);
    case (color)
      COLOR_Y0:           colorInMode = 1'b1;
      COLOR_Y1:           colorInMode = (mode == MODE_422) || (mode == MODE_420);
      COLOR_Y2, COLOR_Y3: colorInMode = (mode == MODE_420);
      COLOR_CB, COLOR_CR: colorInMode = (mode != MODE_GRAY);
      default:            colorInMode = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/aq_djpeg_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port that holds
// its last value until the next read. The array itself is never reset.
module aq_djpeg_sdp_ram #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [$clog2(DEPTH)-1:0] wrAddr,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  input  logic [$clog2(DEPTH)-1:0] rdAddr,
  output logic [WIDTH-1:0]         rdData
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  // Registered read; the output register is cleared by reset, the array is not
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdData <= '0;
    end else if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/aq_djpeg_ycbcr_bank.sv
// Multi-bank MCU buffer between the JPEG IDCT and the colour converter.
// Blocks are written in block/raster order; complete MCUs are read per pixel.
module aq_djpeg_ycbcr_bank
  import aq_djpeg_pkg::*;
#(
  parameter int DW       = 9,
  parameter int NBANK    = 4,
  parameter int CNEUTRAL = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          DataInit,
  input  logic [1:0]    JpegMode,
  input  logic          DataInEnable,
  input  logic [2:0]    DataInColor,
  input  logic [5:0]    DataInAddress,
  input  logic [DW-1:0] DataIn,
  output logic          DataInFull,
  output logic          Overflow,
  output logic          DataOutEnable,
  input  logic          DataOutRead,
  input  logic [7:0]    DataOutAddress,
  input  logic          DataOutReadNext,
  output logic [DW-1:0] DataOutY,
  output logic [DW-1:0] DataOutCb,
  output logic [DW-1:0] DataOutCr
);

  localparam int PW = $clog2(NBANK);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULLCNT = CW'(NBANK);

  logic [PW-1:0] wPtr;
  logic [PW-1:0] rPtr;
  logic [CW-1:0] count;
  logic          overflowR;
  jpegMode_t     modeR;
  logic          grayOutR;

  logic          wrAccept;
  logic          commit;
  logic          releaseBank;
  logic          yWrEn;
  logic          cbWrEn;
  logic          crWrEn;
  logic [1:0]    yBlk;
  logic [5:0]    cOff;
  logic [3:0]    row;
  logic [3:0]    col;
  logic [DW-1:0] cbQ;
  logic [DW-1:0] crQ;

  assign DataInFull    = (count == FULLCNT);
  assign DataOutEnable = (count != '0);
  assign Overflow      = overflowR;

  // Write acceptance, MCU commit and bank release decode; DataInit blocks all three
  always_comb begin
    wrAccept    = 1'b0;
    commit      = 1'b0;
    releaseBank = 1'b0;
    if (!DataInit) begin
      wrAccept    = DataInEnable && !DataInFull && colorInMode(modeR, DataInColor);
      commit      = wrAccept && (DataInColor == lastBlock(modeR)) && (DataInAddress == 6'd63);
      releaseBank = DataOutReadNext && (count != '0);
    end else begin
      wrAccept    = 1'b0;
      commit      = 1'b0;
      releaseBank = 1'b0;
    end
  end

  assign yWrEn  = wrAccept && !DataInColor[2];
  assign cbWrEn = wrAccept && (DataInColor == COLOR_CB);
  assign crWrEn = wrAccept && (DataInColor == COLOR_CR);

  // Bank pointers, occupancy count, sticky overflow and latched format
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtr      <= '0;
      rPtr      <= '0;
      count     <= '0;
      overflowR <= 1'b0;
      modeR     <= MODE_GRAY;
    end else if (DataInit) begin
      wPtr      <= '0;
      rPtr      <= '0;
      count     <= '0;
      overflowR <= 1'b0;
      modeR     <= jpegMode_t'(JpegMode);
    end else begin
      if (commit) begin
        wPtr <= wPtr + PW'(1);
      end
      if (releaseBank) begin
        rPtr <= rPtr + PW'(1);
      end
      if (commit && !releaseBank) begin
        count <= count + CW'(1);
      end else if (!commit && releaseBank) begin
        count <= count - CW'(1);
      end
      if (DataInEnable && DataInFull) begin
        overflowR <= 1'b1;
      end
    end
  end

  assign row = DataOutAddress[7:4];
  assign col = DataOutAddress[3:0];

  // Pixel position to Y block and chroma sample, following the subsampling format
  always_comb begin
    yBlk = 2'b00;
    cOff = {row[2:0], col[2:0]};
    case (modeR)
      MODE_420: begin
        yBlk = {row[3], col[3]};
        cOff = {row[3:1], col[3:1]};
      end
      MODE_422: begin
        yBlk = {1'b0, col[3]};
        cOff = {row[2:0], col[3:1]};
      end
      default: begin
        yBlk = 2'b00;
        cOff = {row[2:0], col[2:0]};
      end
    endcase
  end

  // Remember whether the current output pair belongs to a grayscale read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grayOutR <= 1'b0;
    end else if (DataOutRead) begin
      grayOutR <= (modeR == MODE_GRAY);
    end
  end

  assign DataOutCb = grayOutR ? DW'(CNEUTRAL) : cbQ;
  assign DataOutCr = grayOutR ? DW'(CNEUTRAL) : crQ;

  aq_djpeg_sdp_ram #(.DEPTH(NBANK * 256), .WIDTH(DW)) uYRam (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (yWrEn),
    .wrAddr ({wPtr, DataInColor[1:0], DataInAddress}),
    .wrData (DataIn),
    .rdEn   (DataOutRead),
    .rdAddr ({rPtr, yBlk, row[2:0], col[2:0]}),
    .rdData (DataOutY)
  );

  aq_djpeg_sdp_ram #(.DEPTH(NBANK * 64), .WIDTH(DW)) uCbRam (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (cbWrEn),
    .wrAddr ({wPtr, DataInAddress}),
    .wrData (DataIn),
    .rdEn   (DataOutRead),
    .rdAddr ({rPtr, cOff}),
    .rdData (cbQ)
  );

  aq_djpeg_sdp_ram #(.DEPTH(NBANK * 64), .WIDTH(DW)) uCrRam (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (crWrEn),
    .wrAddr ({wPtr, DataInAddress}),
    .wrData (DataIn),
    .rdEn   (DataOutRead),
    .rdAddr ({rPtr, cOff}),
    .rdData (crQ)
  );

endmodule

// File: tb/tb_aq_djpeg_ycbcr_bank.sv
// Randomized self-checking bench: a 4-bank and a 2-bank instance share stimulus;
// a per-pixel reference model predicts flags and read data for the selected one.
module tb_aq_djpeg_ycbcr_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       dataInit;
  logic [1:0] jpegMode;
  logic       inEn;
  logic [2:0] inColor;
  logic [5:0] inAddr;
  logic [8:0] dataIn;
  logic       rdEn;
  logic [7:0] rdAddr;
  logic       rdNext;

  logic       full4, ovf4, oe4, full2, ovf2, oe2;
  logic [8:0] y4, cb4, cr4, y2, cb2, cr2;

  always #5 clk = ~clk;

  aq_djpeg_ycbcr_bank #(.DW(9), .NBANK(4), .CNEUTRAL(128)) dut4 (
    .clk(clk), .rst(rst), .DataInit(dataInit), .JpegMode(jpegMode),
    .DataInEnable(inEn), .DataInColor(inColor), .DataInAddress(inAddr), .DataIn(dataIn),
    .DataInFull(full4), .Overflow(ovf4), .DataOutEnable(oe4),
    .DataOutRead(rdEn), .DataOutAddress(rdAddr), .DataOutReadNext(rdNext),
    .DataOutY(y4), .DataOutCb(cb4), .DataOutCr(cr4)
  );

  aq_djpeg_ycbcr_bank #(.DW(9), .NBANK(2), .CNEUTRAL(128)) dut2 (
    .clk(clk), .rst(rst), .DataInit(dataInit), .JpegMode(jpegMode),
    .DataInEnable(inEn), .DataInColor(inColor), .DataInAddress(inAddr), .DataIn(dataIn),
    .DataInFull(full2), .Overflow(ovf2), .DataOutEnable(oe2),
    .DataOutRead(rdEn), .DataOutAddress(rdAddr), .DataOutReadNext(rdNext),
    .DataOutY(y2), .DataOutCb(cb2), .DataOutCr(cr2)
  );

  // reference model state
  int  nb, wp, rp, cnt, mode;
  bit  ovf;
  int  mY [8][256];
  int  mCb[8][64];
  int  mCr[8][64];
  int  expY, expCb, expCr;
  bit  sel;
  int  nChecks = 0;
  int  nFails  = 0;

  task automatic checkVal(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int numY(input int m);
    return (m == 3) ? 4 : (m == 2) ? 2 : 1;
  endfunction

  function automatic bit inMcu(input int m, input int c);
    return (c < numY(m)) || (m != 0 && (c == 4 || c == 5));
  endfunction

  function automatic int lastBlk(input int m);
    return (m == 0) ? 0 : 5;
  endfunction

  // expected pixel values at a given {row,col} of the current read bank
  task automatic refRead(input int a);
    int r, c, blk, off, ci;
    r = a / 16;
    c = a % 16;
    off = (r % 8) * 8 + (c % 8);
    blk = (mode == 3) ? (r / 8) * 2 + (c / 8) : (mode == 2) ? (c / 8) : 0;
    ci  = (mode == 3) ? (r / 2) * 8 + (c / 2) : (mode == 2) ? (r % 8) * 8 + (c / 2) : off;
    expY = mY[rp][blk * 64 + off];
    if (mode == 0) begin
      expCb = 128;
      expCr = 128;
    end else begin
      expCb = mCb[rp][ci];
      expCr = mCr[rp][ci];
    end
  endtask

  // one clock: DUT and model both see the held inputs; strobes drop afterwards
  task automatic step();
    bit com, rel;
    @(posedge clk);
    com = 0;
    rel = 0;
    if (rdEn) refRead(int'(rdAddr));
    if (dataInit) begin
      wp = 0; rp = 0; cnt = 0; ovf = 0; mode = int'(jpegMode);
    end else begin
      if (inEn && cnt == nb) ovf = 1;
      else if (inEn && inMcu(mode, int'(inColor))) begin
        if (inColor < 4) mY[wp][int'(inColor) * 64 + int'(inAddr)] = int'(dataIn);
        else if (inColor == 4) mCb[wp][inAddr] = int'(dataIn);
        else mCr[wp][inAddr] = int'(dataIn);
        if (int'(inColor) == lastBlk(mode) && inAddr == 6'd63) com = 1;
      end
      if (rdNext && cnt > 0) rel = 1;
      if (com) begin wp = (wp + 1) % nb; cnt++; end
      if (rel) begin rp = (rp + 1) % nb; cnt--; end
    end
    @(negedge clk);
    dataInit = 1'b0; inEn = 1'b0; rdEn = 1'b0; rdNext = 1'b0;
  endtask

  task automatic doInit(input int m);
    dataInit = 1'b1;
    jpegMode = 2'(m);
    step();
  endtask

  task automatic writeMcu(input bit idxPat, input bit nxtOnLast);
    for (int c = 0; c < 6; c++) begin
      if (inMcu(mode, c)) begin
        for (int a = 0; a < 64; a++) begin
          inEn    = 1'b1;
          inColor = 3'(c);
          inAddr  = 6'(a);
          dataIn  = idxPat ? 9'((c < 4) ? c * 64 + a : a) : 9'($urandom_range(511, 0));
          rdNext  = nxtOnLast && (c == lastBlk(mode)) && (a == 63);
          step();
        end
      end
    end
  endtask

  task automatic checkFlags(input string tag);
    checkVal({tag, ".full"}, int'(sel ? full2 : full4), int'(cnt == nb));
    checkVal({tag, ".oe"},   int'(sel ? oe2 : oe4),     int'(cnt != 0));
    checkVal({tag, ".ovf"},  int'(sel ? ovf2 : ovf4),   int'(ovf));
  endtask

  task automatic checkOut(input string tag);
    checkVal({tag, ".y"},  int'(sel ? y2 : y4),   expY);
    checkVal({tag, ".cb"}, int'(sel ? cb2 : cb4), expCb);
    checkVal({tag, ".cr"}, int'(sel ? cr2 : cr4), expCr);
  endtask

  task automatic readCheck(input string tag, input int a);
    rdEn   = 1'b1;
    rdAddr = 8'(a);
    step();
    checkOut(tag);
  endtask

  task automatic randReads(input string tag, input int n);
    for (int i = 0; i < n; i++) readCheck(tag, int'($urandom_range(255, 0)));
  endtask

  task automatic releaseBank();
    rdNext = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b0; dataInit = 1'b0; jpegMode = 2'd0; inEn = 1'b0; inColor = 3'd0;
    inAddr = 6'd0; dataIn = 9'd0; rdEn = 1'b0; rdAddr = 8'd0; rdNext = 1'b0;
    nb = 4; wp = 0; rp = 0; cnt = 0; mode = 0; ovf = 0; sel = 0;
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < 256; i++) mY[b][i] = 0;
      for (int i = 0; i < 64; i++) begin mCb[b][i] = 0; mCr[b][i] = 0; end
    end
    expY = 0; expCb = 0; expCr = 0;

    // reset state
    #2 rst = 1'b1;
    #2;
    checkFlags("reset");
    checkOut("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 4:2:0, value = index, one MCU then a known read
    doInit(3);
    writeMcu(1'b1, 1'b0);
    checkVal("s1.count_is_1", int'(oe4), 1);
    checkFlags("s1");
    readCheck("s1.rd99", 8'h99);
    checkVal("s1.y3_9", int'(y4), 201);
    checkVal("s1.cb36", int'(cb4), 36);
    step(); step();
    checkOut("s1.hold");
    randReads("s1.rand", 6);

    // fill all four banks, overflow on a fifth write
    for (int i = 0; i < 3; i++) writeMcu(1'b0, 1'b0);
    checkFlags("s2.full");
    inEn = 1'b1; inColor = 3'd0; inAddr = 6'd0; dataIn = 9'h1AA;
    step();
    checkFlags("s2.ovf");
    readCheck("s2.nocorrupt", 8'h00);
    releaseBank();
    checkFlags("s2.released");

    // commit and release in the same cycle with two banks occupied
    releaseBank();
    checkFlags("s3.pre");
    writeMcu(1'b0, 1'b1);
    checkFlags("s3.same");
    randReads("s3.bankA", 3);
    releaseBank();
    randReads("s3.bankB", 3);
    releaseBank();
    checkFlags("s3.empty");
    releaseBank();
    checkFlags("s3.idle_next");

    // grayscale: chroma writes ignored, Y0 alone commits
    doInit(0);
    for (int a = 60; a < 64; a++) begin
      inEn = 1'b1; inColor = 3'd4; inAddr = 6'(a); dataIn = 9'($urandom_range(511, 0));
      step();
    end
    inEn = 1'b1; inColor = 3'd5; inAddr = 6'd63; dataIn = 9'd7;
    step();
    checkFlags("s4.nocommit");
    writeMcu(1'b0, 1'b0);
    checkFlags("s4.commit");
    randReads("s4.rand", 5);

    // reset in the middle of a 4:2:0 MCU
    doInit(3);
    for (int c = 0; c < 2; c++) begin
      for (int a = 0; a < 64; a++) begin
        inEn = 1'b1; inColor = 3'(c); inAddr = 6'(a); dataIn = 9'($urandom_range(511, 0));
        step();
      end
    end
    readCheck("s6.pre", 8'h17);
    for (int a = 0; a < 20; a++) begin
      inEn = 1'b1; inColor = 3'd2; inAddr = 6'(a); dataIn = 9'($urandom_range(511, 0));
      step();
    end
    rst = 1'b1;
    #1;
    wp = 0; rp = 0; cnt = 0; ovf = 0; mode = 0;
    expY = 0; expCb = 0; expCr = 0;
    checkFlags("s6.rst");
    checkOut("s6.rst");
    @(negedge clk);
    rst = 1'b0;
    readCheck("s6.grayneutral", 8'h00);
    writeMcu(1'b0, 1'b0);
    checkFlags("s6.commit");
    randReads("s6.bank0", 4);

    // two banks, 4:2:2, five MCUs streamed across pointer wrap
    sel = 1; nb = 2;
    doInit(2);
    writeMcu(1'b0, 1'b0);
    writeMcu(1'b0, 1'b0);
    checkFlags("s5.full");
    inEn = 1'b1; inColor = 3'd4; inAddr = 6'd5; dataIn = 9'd3;
    step();
    checkFlags("s5.ovf");
    for (int i = 0; i < 5; i++) begin
      randReads("s5.rd", 3);
      releaseBank();
      if (i < 3) writeMcu(1'b0, 1'b0);
    end
    checkFlags("s5.end");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
